// File: rtl/pc_gen_pkg.sv
// pc_gen shared constants: npc_src encodings and default vectors.
// Optional alignment check is enabled by PC_GEN_ALIGN_CHK_EN.
package pc_gen_pkg;

   localparam logic [2:0] NPC_SEQ  = 3'b000;
   localparam logic [2:0] NPC_BR   = 3'b001;
   localparam logic [2:0] NPC_J    = 3'b010;
   localparam logic [2:0] NPC_JR   = 3'b011;
   localparam logic [2:0] NPC_JAL  = 3'b100;
   localparam logic [2:0] NPC_JRRA = 3'b101;
   localparam logic [2:0] NPC_ERET = 3'b110;
   localparam logic [2:0] NPC_RSVD = 3'b111;

   localparam logic [31:0] RESET_PC_DEF = 32'hBFC0_0000;
   localparam logic [31:0] EXC_VEC_DEF  = 32'h8000_0180;

endpackage

// File: rtl/pc_gen_if.sv
// Redirect controls in, fetch PC state out, for pc_gen.
// adel exists only when PC_GEN_ALIGN_CHK_EN is defined.
interface pc_gen_if;

   logic        stall;
   logic [2:0]  npc_src;
   logic [31:0] imm;
   logic [25:0] jaddr;
   logic [31:0] raddr;
   logic        exc_req;
   logic [31:0] pc;
   logic [31:0] pc_4;
   logic [31:0] npc;
   logic [31:0] epc;
   logic [31:0] ras_top;
   logic        ras_valid;
   logic        ras_mispredict;
`ifdef PC_GEN_ALIGN_CHK_EN
   logic        adel;
`endif

   modport master (
      output stall, npc_src, imm, jaddr, raddr, exc_req,
`ifdef PC_GEN_ALIGN_CHK_EN
      input  adel,
`endif
      input  pc, pc_4, npc, epc,
      input  ras_top, ras_valid, ras_mispredict
   );

   modport slave (
      input  stall, npc_src, imm, jaddr, raddr, exc_req,
`ifdef PC_GEN_ALIGN_CHK_EN
      output adel,
`endif
      output pc, pc_4, npc, epc,
      output ras_top, ras_valid, ras_mispredict
   );

endinterface

// File: rtl/pc_ras.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
module pc_ras #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        push,
   input  logic        pop,
   input  logic [31:0] push_data,
   output logic [31:0] top,
   output logic        valid
);

   localparam int AW = $clog2(DEPTH);

   logic [31:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   cnt;

   assign rd_ptr = wr_ptr - AW'(1);
   assign valid  = (cnt != '0);
   assign top    = valid ? mem[rd_ptr] : '0;

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         cnt    <= '0;
      end else if (push) begin
         wr_ptr <= wr_ptr + AW'(1);
         if (cnt != (AW+1)'(DEPTH))
            cnt <= cnt + 1'b1;
      end else if (pop && valid) begin
         wr_ptr <= rd_ptr;
         cnt    <= cnt - 1'b1;
      end
   end

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator: PC/EPC registers, next-PC select and RAS.
// Define PC_GEN_ALIGN_CHK_EN to trap misaligned register/eret targets.
module pc_gen
   import pc_gen_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
   parameter logic [31:0] EXC_VEC   = EXC_VEC_DEF,
   parameter int          RAS_DEPTH = 4
) (
   input logic     clk,
   input logic     rst_n,
   pc_gen_if.slave bus
);

   logic [31:0] pc_q;
   logic [31:0] epc_q;
   logic [31:0] pc_4;
   logic [31:0] br_tgt;
   logic [31:0] j_tgt;
   logic [31:0] tgt;
   logic [31:0] npc;
   logic        upd;
   logic        push;
   logic        pop;
   logic [31:0] ras_top;
   logic        ras_valid;
   logic        misalign;
   logic        unused_imm;

   assign unused_imm = ^bus.imm[31:30];

   assign pc_4   = pc_q + 32'd4;
   assign br_tgt = pc_4 + {bus.imm[29:0], 2'b00};
   assign j_tgt  = {pc_4[31:28], bus.jaddr, 2'b00};

   always_comb begin
      tgt = pc_4;
      unique case (bus.npc_src)
         NPC_SEQ:  tgt = pc_4;
         NPC_BR:   tgt = br_tgt;
         NPC_J:    tgt = j_tgt;
         NPC_JR:   tgt = bus.raddr;
         NPC_JAL:  tgt = j_tgt;
         NPC_JRRA: tgt = bus.raddr;
         NPC_ERET: tgt = epc_q;
         NPC_RSVD: tgt = EXC_VEC;
      endcase
   end

`ifdef PC_GEN_ALIGN_CHK_EN
   assign misalign = !bus.exc_req && (tgt[1:0] != 2'b00) &&
                     (bus.npc_src == NPC_JR ||
                      bus.npc_src == NPC_JRRA ||
                      bus.npc_src == NPC_ERET);
   assign bus.adel = misalign;
`else
   assign misalign = 1'b0;
`endif

   assign npc = (bus.exc_req || misalign) ? EXC_VEC : tgt;

   // RAS only moves on an edge that actually advances the PC
   assign upd  = !bus.stall && !bus.exc_req;
   assign push = upd && (bus.npc_src == NPC_JAL);
   assign pop  = upd && (bus.npc_src == NPC_JRRA);

   pc_ras #(.DEPTH(RAS_DEPTH)) u_ras (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .pop       (pop),
      .push_data (pc_q + 32'd8),
      .top       (ras_top),
      .valid     (ras_valid)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc_q  <= RESET_PC;
         epc_q <= '0;
      end else if (bus.exc_req) begin
         pc_q  <= EXC_VEC;
         epc_q <= pc_q;
      end else if (!bus.stall) begin
         pc_q <= npc;
         if (misalign)
            epc_q <= tgt;
      end
   end

   assign bus.pc             = pc_q;
   assign bus.pc_4           = pc_4;
   assign bus.npc            = npc;
   assign bus.epc            = epc_q;
   assign bus.ras_top        = ras_top;
   assign bus.ras_valid      = ras_valid;
   assign bus.ras_mispredict = pop && (!ras_valid || ras_top != bus.raddr);

endmodule

// File: tb/tb_pc_gen.sv
// Directed-vector bench for pc_gen with hand-computed expectations.
module tb_pc_gen;

   logic clk = 1'b0;
   logic rst_n;
   int   n_cmp = 0;
   int   n_err = 0;

   pc_gen_if bus ();

   pc_gen dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic go(input logic [2:0] src);
      bus.npc_src = src;
      step();
   endtask

   task automatic jump_to(input logic [31:0] a);
      bus.raddr = a;
      go(3'b011);
   endtask

   initial begin
      rst_n       = 1'b0;
      bus.stall   = 1'b0;
      bus.npc_src = 3'b000;
      bus.imm     = '0;
      bus.jaddr   = '0;
      bus.raddr   = '0;
      bus.exc_req = 1'b0;
      step();
      step();
      chk("rst_pc", bus.pc, 32'hBFC0_0000);
      chk("rst_epc", bus.epc, 32'h0);
      chk("rst_rv", 32'(bus.ras_valid), 32'd0);
      chk("rst_top", bus.ras_top, 32'h0);
      chk("rst_mis", 32'(bus.ras_mispredict), 32'd0);
      rst_n = 1'b1;
      chk("seq_pc4", bus.pc_4, 32'hBFC0_0004);
      go(3'b000);
      chk("seq1", bus.pc, 32'hBFC0_0004);
      go(3'b000);
      chk("seq2", bus.pc, 32'hBFC0_0008);
      go(3'b000);
      chk("seq3", bus.pc, 32'hBFC0_000C);
      chk("seq_rv", 32'(bus.ras_valid), 32'd0);

      // branch back and jump
      jump_to(32'hBFC0_0010);
      bus.npc_src = 3'b001;
      bus.imm     = 32'hFFFF_FFFC;
      #1;
      chk("br_npc", bus.npc, 32'hBFC0_0004);
      step();
      chk("br_pc", bus.pc, 32'hBFC0_0004);
      jump_to(32'hBFC0_0010);
      bus.jaddr = 26'h0000040;
      go(3'b010);
      chk("j_pc", bus.pc, 32'hB000_0100);

      // stall, exception under stall, eret
      jump_to(32'hBFC0_0020);
      bus.stall = 1'b1;
      for (int i = 0; i < 3; i++) go(3'b000);
      chk("stall_pc", bus.pc, 32'hBFC0_0020);
      bus.exc_req = 1'b1;
      #1;
      chk("exc_npc", bus.npc, 32'h8000_0180);
      step();
      chk("exc_pc", bus.pc, 32'h8000_0180);
      chk("exc_epc", bus.epc, 32'hBFC0_0020);
      bus.exc_req = 1'b0;
      bus.stall   = 1'b0;
      go(3'b110);
      chk("eret_pc", bus.pc, 32'hBFC0_0020);

      // RAS match then mismatch
      jump_to(32'h0000_1000);
      bus.jaddr = 26'h0000800;
      go(3'b100);
      chk("jal_pc", bus.pc, 32'h0000_2000);
      chk("jal_top", bus.ras_top, 32'h0000_1008);
      bus.npc_src = 3'b101;
      bus.raddr   = 32'h0000_1008;
      #1;
      chk("ra_hit", 32'(bus.ras_mispredict), 32'd0);
      step();
      chk("ra_pc", bus.pc, 32'h0000_1008);
      chk("ra_rv", 32'(bus.ras_valid), 32'd0);
      jump_to(32'h0000_1000);
      go(3'b100);
      bus.npc_src = 3'b101;
      bus.raddr   = 32'h0000_100C;
      #1;
      chk("ra_miss", 32'(bus.ras_mispredict), 32'd1);
      step();
      chk("ra_miss_rv", 32'(bus.ras_valid), 32'd0);

      // stalled jal / jr_ra leave the RAS alone
      bus.stall = 1'b1;
      go(3'b100);
      chk("stl_push", 32'(bus.ras_valid), 32'd0);
      bus.npc_src = 3'b101;
      #1;
      chk("stl_mis", 32'(bus.ras_mispredict), 32'd0);
      bus.stall = 1'b0;

      // wrap: five pushes into four entries
      bus.jaddr = 26'h0000040;
      for (int i = 1; i <= 5; i++) begin
         jump_to(32'(i) * 32'h100);
         go(3'b100);
      end
      chk("wrap_top", bus.ras_top, 32'h0000_0508);
      for (int i = 5; i >= 2; i--) begin
         bus.npc_src = 3'b101;
         bus.raddr   = 32'(i) * 32'h100 + 32'h8;
         #1;
         chk("pop_top", bus.ras_top, bus.raddr);
         chk("pop_mis", 32'(bus.ras_mispredict), 32'd0);
         step();
      end
      chk("pop_rv", 32'(bus.ras_valid), 32'd0);
      bus.raddr = 32'h0000_0108;
      #1;
      chk("empty_mis", 32'(bus.ras_mispredict), 32'd1);
      step();
      chk("empty_rv", 32'(bus.ras_valid), 32'd0);
      chk("empty_top", bus.ras_top, 32'h0);

      // misaligned register target
      bus.npc_src = 3'b011;
      bus.raddr   = 32'h0000_1002;
      #1;
`ifdef PC_GEN_ALIGN_CHK_EN
      chk("adel_npc", bus.npc, 32'h8000_0180);
      chk("adel", 32'(bus.adel), 32'd1);
      step();
      chk("adel_pc", bus.pc, 32'h8000_0180);
      chk("adel_epc", bus.epc, 32'h0000_1002);
`else
      chk("mis_npc", bus.npc, 32'h0000_1002);
      step();
      chk("mis_pc", bus.pc, 32'h0000_1002);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised successor to the combinational next-PC selector.
- Owns the architectural PC register and the EPC register, plus a circular return-address stack (RAS) fed by jal and checked by jr $ra.
- Sits at the front of the fetch stage. Consumes decode/execute redirect controls and drives the fetch address every cycle.

Parameters:
- RESET_PC, 32'hBFC0_0000, PC value loaded on reset.
- EXC_VEC, 32'h8000_0180, exception/trap target.
- RAS_DEPTH, 4, RAS entries; power of two, at least 2.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- stall  in  1  hold PC and RAS this cycle.
- npc_src  in  3  redirect select (encoding below).
- imm  in  32  sign-extended branch offset, in words.
- jaddr  in  26  j/jal instruction index.
- raddr  in  32  register-jump target.
- exc_req  in  1  take exception this cycle.
- pc  out  32  current fetch PC (registered).
- pc_4  out  32  pc + 4.
- npc  out  32  combinational next PC.
- epc  out  32  saved exception PC (registered).
- ras_top  out  32  RAS top entry, or 0 when empty.
- ras_valid  out  1  RAS non-empty.
- ras_mispredict  out  1  pop with empty RAS, or ras_top != raddr.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low (rst_n).
  - On a clk edge with rst_n=0: pc=RESET_PC, epc=0, RAS count=0, RAS pointer=0.
  - Combinational outputs then follow: ras_valid=0, ras_top=0, ras_mispredict=0.
  - Reset overrides stall and exc_req.
- npc_src encoding:
  - 000 seq: pc_4.
  - 001 branch: pc_4 + {imm[29:0],2'b00}, 32-bit wrap.
  - 010 j: {pc_4[31:28], jaddr, 2'b00}.
  - 011 jr: raddr.
  - 100 jal: same target as j; pushes pc + 8 onto RAS (return address skips the delay slot).
  - 101 jr_ra: raddr; pops RAS; ras_mispredict valid this cycle.
  - 110 eret: epc.
  - 111 reserved: EXC_VEC.
- Priority of npc: exc_req beats npc_src. exc_req=1 gives npc=EXC_VEC.
- Update on each clk edge with rst_n=1:
  - exc_req=1: pc<=EXC_VEC and epc<=pc. This ignores stall. The RAS is unchanged.
  - else stall=1: pc, epc and RAS all hold.
  - else: pc<=npc, and the RAS op per npc_src is performed.
- Latency: npc, pc_4 and ras_mispredict are combinational from the current pc and inputs. pc changes one edge later.
- RAS is circular, with pointer wr_ptr and count 0..RAS_DEPTH.
  - Push: entry[wr_ptr]<=value, wr_ptr++ modulo RAS_DEPTH, count saturates at RAS_DEPTH.
  - Push when full overwrites the oldest entry (wrap); no error.
  - Pop when count>0: wr_ptr--, count--.
  - Pop when empty: no state change, ras_mispredict=1.
  - ras_top = entry[wr_ptr-1] when count>0.
  - ras_mispredict is 0 unless npc_src=101 and neither stall nor exc_req is asserted.
- Only one RAS op per cycle is possible, since npc_src is one-hot in effect.

Optional Feature:
- Macro: PC_GEN_ALIGN_CHK_EN.
- When defined:
  - Adds output port adel (1 bit).
  - Any non-exception target with npc[1:0]!=0 (jr/jr_ra/eret) is replaced by EXC_VEC and raises adel=1 combinationally.
  - On the update edge (not stalled), epc<=the offending target.
  - RAS pop still occurs for jr_ra.
- When undefined: no adel port. Misaligned targets pass through unchanged.

Decomposition:
- Package pc_gen_pkg holds:
  - npc_src localparams: NPC_SEQ, NPC_BR, NPC_J, NPC_JR, NPC_JAL, NPC_JRRA, NPC_ERET, NPC_RSVD.
  - Default RESET_PC and EXC_VEC constants.
- One sub-module, pc_ras: parametrised circular stack.
  - Inputs: push, pop, push_data.
  - Outputs: top, valid.
  - Uses the same clk/rst_n.

Test Plan:
- Reset: rst_n=0 for 2 cycles, then npc_src=000 for 3 cycles -> pc sequence BFC0_0000, BFC0_0004, BFC0_0008, BFC0_000C; ras_valid=0.
- Branch and jump: with pc=BFC0_0010:
  - npc_src=001, imm=FFFF_FFFC -> next pc=BFC0_0004.
  - npc_src=010, jaddr=26'h0000040 -> next pc=B000_0100.
- Stall vs exception:
  - stall=1 for 3 cycles -> pc holds.
  - stall=1 with exc_req=1 at pc=BFC0_0020 -> pc=8000_0180, epc=BFC0_0020.
  - npc_src=110 -> pc=BFC0_0020.
- RAS match: jal at pc=1000 (target 2000), then jr_ra with raddr=1008 -> ras_mispredict=0, ras_valid=0 afterwards.
  - Repeat with raddr=100C -> ras_mispredict=1.
- RAS wrap: 5 jals at pc=100,200,300,400,500, then 5 jr_ra pops.
  - First four pops give ras_top=508, 408, 308, 208 (entry 108 overwritten).
  - Fifth pop gives ras_mispredict=1 and count stays 0.
- Alignment (PC_GEN_ALIGN_CHK_EN defined): npc_src=011, raddr=0000_1002 -> npc=8000_0180, adel=1, epc=0000_1002.
  - Without the macro: pc=0000_1002.
